// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 key event decoder: make/break/extended-prefix FSM, held-key vector and press/release
// events, all synchronous to CLOCK_50. Define KEY_EVENT_FIFO_EN to queue events in a small FIFO.
module ps2_key_event_decoder #(
   parameter int unsigned PREFIX_TIMEOUT = 2_500_000,
   parameter int unsigned FIFO_AW        = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [7:0]  recievedData,
   input  logic        recievedNewData,
   output logic [28:0] key_state,
   output logic        any_key,
   output logic        event_valid,
   output logic        event_is_press,
   output logic [4:0]  event_key,
   input  logic        event_ready,
   output logic        event_overflow
);

   localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

   state_e           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             hit;
   logic [4:0]       idx;
   logic             do_make, do_rel, ev_fire;

   always_comb begin
      hit = 1'b1;
      idx = 5'd0;
      case (recievedData)
         8'h0E: idx = 5'd0;   8'h16: idx = 5'd1;   8'h1E: idx = 5'd2;   8'h26: idx = 5'd3;
         8'h25: idx = 5'd4;   8'h2E: idx = 5'd5;   8'h36: idx = 5'd6;   8'h3D: idx = 5'd7;
         8'h3E: idx = 5'd8;   8'h46: idx = 5'd9;   8'h45: idx = 5'd10;  8'h4E: idx = 5'd11;
         8'h55: idx = 5'd12;  8'h66: idx = 5'd13;  8'h0D: idx = 5'd14;  8'h15: idx = 5'd15;
         8'h1D: idx = 5'd16;  8'h24: idx = 5'd17;  8'h2D: idx = 5'd18;  8'h2C: idx = 5'd19;
         8'h35: idx = 5'd20;  8'h3C: idx = 5'd21;  8'h43: idx = 5'd22;  8'h44: idx = 5'd23;
         8'h4D: idx = 5'd24;  8'h54: idx = 5'd25;  8'h5B: idx = 5'd26;  8'h5D: idx = 5'd27;
         8'h29: idx = 5'd28;
         default: hit = 1'b0;
      endcase
   end

   assign do_make = recievedNewData && (state == StIdle) && hit;
   assign do_rel  = recievedNewData && (state == StBreak) && hit;
   // Typematic repeats and releases of unheld keys change nothing, so they raise no event.
   assign ev_fire = (do_make && !key_state[idx]) || (do_rel && key_state[idx]);
   assign any_key = |key_state;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= StIdle;
         tmo_cnt   <= '0;
         key_state <= '0;
      end else if (recievedNewData) begin
         tmo_cnt <= '0;
         case (state)
            StIdle:
               if (recievedData == 8'hF0)      state <= StBreak;
               else if (recievedData == 8'hE0) state <= StExt;
               else                            state <= StIdle;
            StBreak:
               if (recievedData == 8'hF0)      state <= StBreak;
               else if (recievedData == 8'hE0) state <= StExtBreak;
               else                            state <= StIdle;
            StExt:
               if (recievedData == 8'hF0)      state <= StExtBreak;
               else                            state <= StIdle;
            default: state <= StIdle;
         endcase
         if (do_make) key_state[idx] <= 1'b1;
         if (do_rel)  key_state[idx] <= 1'b0;
      end else if (state == StIdle || tmo_cnt == CNT_LAST) begin
         tmo_cnt <= '0;
         state   <= StIdle;
      end else begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

`ifdef KEY_EVENT_FIFO_EN
   localparam int unsigned DEPTH = 2 ** FIFO_AW;

   logic [5:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             empty, full, push, pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop   = !empty && event_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is not dropped then.
   assign push  = ev_fire && (!full || pop);

   assign event_valid                 = !empty;
   assign {event_is_press, event_key} = mem[rd_ptr[FIFO_AW-1:0]];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         event_overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {do_make, idx};
            wr_ptr                   <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (ev_fire && full && !pop) event_overflow <= 1'b1;
      end
   end
`else
   logic             unused_event_ready;
   logic [FIFO_AW:0] unused_fifo_aw;
   assign unused_event_ready = event_ready;
   assign unused_fifo_aw     = '0;
   assign event_overflow     = 1'b0;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         event_valid    <= 1'b0;
         event_is_press <= 1'b0;
         event_key      <= 5'd0;
      end else begin
         event_valid <= ev_fire;
         if (ev_fire) begin
            event_is_press <= do_make;
            event_key      <= idx;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed self-checking bench for ps2_key_event_decoder; FIFO checks run when KEY_EVENT_FIFO_EN
// is defined.
module tb_ps2_key_event_decoder;

   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  data = 8'h00;
   logic        strobe = 1'b0;
   logic        ready = 1'b1;
   logic [28:0] key_state;
   logic        any_key, event_valid, event_is_press, event_overflow;
   logic [4:0]  event_key;

   int tests = 0;
   int fails = 0;
   int ev_count = 0;
   int base;

   ps2_key_event_decoder #(.PREFIX_TIMEOUT(TMO), .FIFO_AW(2)) dut (
      .CLOCK_50       (clk),
      .reset          (reset),
      .recievedData   (data),
      .recievedNewData(strobe),
      .key_state      (key_state),
      .any_key        (any_key),
      .event_valid    (event_valid),
      .event_is_press (event_is_press),
      .event_key      (event_key),
      .event_ready    (ready),
      .event_overflow (event_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (event_valid === 1'b1) ev_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      data   = b;
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      idle(3);
      reset = 1'b0;
      idle(1);
      check("rst_key_state", 32'(key_state), 0);
      check("rst_any_key", 32'(any_key), 0);
      check("rst_valid", 32'(event_valid), 0);
      check("rst_press", 32'(event_is_press), 0);
      check("rst_key", 32'(event_key), 0);
      check("rst_overflow", 32'(event_overflow), 0);

      // Make then break of 1D (idx 16)
      send(8'h1D);
      check("t1_state", 32'(key_state), 32'h0001_0000);
      check("t1_any", 32'(any_key), 1);
      check("t1_valid", 32'(event_valid), 1);
      check("t1_press", 32'(event_is_press), 1);
      check("t1_key", 32'(event_key), 16);
      send(8'hF0);
      check("t1_f0_novalid", 32'(event_valid), 0);
      check("t1_f0_held", 32'(key_state), 32'h0001_0000);
      send(8'h1D);
      check("t1_rel_state", 32'(key_state), 0);
      check("t1_rel_any", 32'(any_key), 0);
      check("t1_rel_valid", 32'(event_valid), 1);
      check("t1_rel_press", 32'(event_is_press), 0);
      check("t1_rel_key", 32'(event_key), 16);
      check("t1_evcount", 32'(ev_count), 2);
`ifndef KEY_EVENT_FIFO_EN
      idle(2);
      check("t1_hold_key", 32'(event_key), 16);
      check("t1_pulse_low", 32'(event_valid), 0);
`endif

      // Typematic repeat of 29 (idx 28)
      base = ev_count;
      send(8'h29); send(8'h29); send(8'h29);
      check("t2_press_count", 32'(ev_count - base), 1);
      check("t2_state", 32'(key_state), 32'h1000_0000);
      check("t2_key", 32'(event_key), 28);
      send(8'hF0); send(8'h29);
      check("t2_rel_count", 32'(ev_count - base), 2);
      check("t2_rel_press", 32'(event_is_press), 0);
      send(8'hF0); send(8'h29);
      check("t2_rel_unheld", 32'(ev_count - base), 2);

      // Extended keys never touch key_state, even when the second byte is a mapped code
      base = ev_count;
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hE0); send(8'h1D);
      check("t3_ext_count", 32'(ev_count - base), 0);
      check("t3_ext_state", 32'(key_state), 0);
      send(8'h15);
      check("t3_press_count", 32'(ev_count - base), 1);
      check("t3_press_key", 32'(event_key), 15);
      check("t3_state", 32'(key_state), 32'h0000_8000);

      // Break inside the window releases; after a timed-out F0 the byte is a make
      send(8'hF0); idle(2); send(8'h15);
      check("t4_in_window_rel", 32'(key_state), 0);
      check("t4_in_window_press", 32'(event_is_press), 0);
      base = ev_count;
      send(8'hF0);
      idle(TMO + 4);
      send(8'h15);
      check("t4_tmo_count", 32'(ev_count - base), 1);
      check("t4_tmo_press", 32'(event_is_press), 1);
      check("t4_tmo_key", 32'(event_key), 15);
      check("t4_tmo_state", 32'(key_state), 32'h0000_8000);

      // Unmapped byte in BREAK aborts to IDLE
      send(8'hF0); send(8'hAA); send(8'h15);
      check("t4_aa_still_held", 32'(key_state), 32'h0000_8000);

      // Reset mid-stream with a prefix pending
      send(8'h16); send(8'h1E); send(8'hF0);
      check("t5_pre_state", 32'(key_state), 32'h0000_8006);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      check("t5_state", 32'(key_state), 0);
      check("t5_valid", 32'(event_valid), 0);
      check("t5_any", 32'(any_key), 0);
      base = ev_count;
      send(8'hF0); send(8'h16);
      check("t5_no_event", 32'(ev_count - base), 0);
      send(8'h16);
      check("t5_idle_press", 32'(ev_count - base), 1);
      check("t5_idle_key", 32'(event_key), 1);

`ifdef KEY_EVENT_FIFO_EN
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0; ready = 1'b0; #1;
      send(8'h0E); send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      check("t6_overflow", 32'(event_overflow), 1);
      check("t6_valid", 32'(event_valid), 1);
      check("t6_state", 32'(key_state), 32'h0000_001F);
      for (int i = 0; i < 4; i++) begin
         check("t6_drain_key", 32'(event_key), i);
         check("t6_drain_press", 32'(event_is_press), 1);
         @(negedge clk); ready = 1'b1;
         @(negedge clk); ready = 1'b0; #1;
      end
      check("t6_empty", 32'(event_valid), 0);
      check("t6_overflow_sticky", 32'(event_overflow), 1);
      ready = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      fails++;
      $error("FAIL watchdog: observed timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
